// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS table reader.
// Also holds the LFSR constants used when DDS_PHASE_DITHER_EN is defined.
package dds_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} dds_state_t;

    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_PHASE_WIDTH = 32;
    localparam int DEF_CNT_WIDTH   = 16;

    // Right-shift Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with tuning-word shadow register; pending words are
// applied only on a wrap so the phase stays continuous.
module dds_phase_acc #(
    parameter int PHASE_WIDTH = 32,
    parameter int TAP_W       = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_fire,
    input  logic                   advance,
    input  logic                   ftw_load,
    input  logic [PHASE_WIDTH-1:0] ftw_in,
    output logic [TAP_W-1:0]       phase_tap,
    output logic                   wrap
);

    logic [PHASE_WIDTH-1:0] phase_reg;
    logic [PHASE_WIDTH-1:0] ftw_active_reg;
    logic [PHASE_WIDTH-1:0] ftw_shadow_reg;
    logic                   pending_reg;
    logic [PHASE_WIDTH:0]   sum;

    assign sum       = {1'b0, phase_reg} + {1'b0, ftw_active_reg};
    assign wrap      = advance & sum[PHASE_WIDTH];
    assign phase_tap = phase_reg[PHASE_WIDTH-1 -: TAP_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg      <= '0;
            ftw_active_reg <= '0;
            ftw_shadow_reg <= '0;
            pending_reg    <= 1'b0;
        end else begin
            if (ftw_load) begin
                ftw_shadow_reg <= ftw_in;
                pending_reg    <= 1'b1;
            end
            if (start_fire) begin
                // A word loaded together with start is used straight away
                phase_reg      <= '0;
                ftw_active_reg <= ftw_load ? ftw_in : ftw_shadow_reg;
                pending_reg    <= 1'b0;
            end else if (advance) begin
                phase_reg <= sum[PHASE_WIDTH-1:0];
                if (wrap && pending_reg) begin
                    ftw_active_reg <= ftw_shadow_reg;
                    pending_reg    <= ftw_load;
                end
            end
        end
    end

endmodule

// File: rtl/dds_table_reader.sv
// Waveform table playback: phase accumulator addressing, counted or continuous
// periods, registered sample output. Optional address dither: DDS_PHASE_DITHER_EN.
module dds_table_reader
    import dds_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PHASE_WIDTH-1:0] ftw_in,
    input  logic                   ftw_load,
    input  logic [ADDR_WIDTH-1:0]  phase_off,
    input  logic [CNT_WIDTH-1:0]   cycles_in,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]  mem_data,
    output logic [DATA_WIDTH-1:0]  sample_out,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int FRAC_W = PHASE_WIDTH - ADDR_WIDTH;
    localparam int DITH_W = (FRAC_W > 16) ? 16 : FRAC_W;
`ifdef DDS_PHASE_DITHER_EN
    localparam int TAP_W = ADDR_WIDTH + DITH_W;
`else
    localparam int TAP_W = ADDR_WIDTH;
`endif

    dds_state_t            state_reg, state_next;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
    logic                  done_next;
    logic [DATA_WIDTH-1:0] sample_out_reg;
    logic                  sample_valid_reg, busy_reg, done_reg;
    logic                  start_fire, advance, wrap;
    logic [TAP_W-1:0]      phase_tap;
    logic [ADDR_WIDTH-1:0] addr_base;

    assign start_fire = (state_reg == IDLE) && start && !stop;
    // A stop cycle still registers its sample but freezes phase and count
    assign advance    = (state_reg == RUN) && !stop;

    dds_phase_acc #(
        .PHASE_WIDTH(PHASE_WIDTH),
        .TAP_W      (TAP_W)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .start_fire(start_fire),
        .advance   (advance),
        .ftw_load  (ftw_load),
        .ftw_in    (ftw_in),
        .phase_tap (phase_tap),
        .wrap      (wrap)
    );

`ifdef DDS_PHASE_DITHER_EN
    logic [15:0]      lfsr_reg;
    logic [TAP_W-1:0] dith_sum;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr_reg <= LFSR_SEED;
        else if (state_reg == RUN)
            lfsr_reg <= lfsr_step(lfsr_reg);
    end

    // Noise lands on the discarded fraction bits; at most +1 on the address
    assign dith_sum  = phase_tap + TAP_W'(lfsr_reg[15 -: DITH_W]);
    assign addr_base = dith_sum[TAP_W-1 -: ADDR_WIDTH];
`else
    assign addr_base = phase_tap;
`endif

    assign mem_addr = addr_base + phase_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_fire) begin
                    state_next = RUN;
                    cnt_next   = cycles_in;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (wrap && cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == CNT_WIDTH'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out_reg   <= '0;
            sample_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            if (state_reg == RUN)
                sample_out_reg <= mem_data;
            sample_valid_reg <= (state_reg == RUN);
            busy_reg         <= (state_reg == RUN);
            done_reg         <= done_next;
        end
    end

    assign sample_out   = sample_out_reg;
    assign sample_valid = sample_valid_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;

endmodule

// File: doc/dds_table_reader.md
Name: dds_table_reader

Overview:
- Playback engine that reads the waveform table held in the team's block RAM. It is the read side paired with the host-side table writer.
- A phase accumulator generates table addresses. Each word read back is registered and presented as a sample stream with a valid strobe.
- Sits between the waveform blockram (driving its addr, reading its data_out) and the downstream DAC/output formatter.
- Supports continuous or counted-period playback, phase-continuous frequency updates and a phase offset.

Parameters:
- ADDR_WIDTH, 12, table address width; must match the blockram.
- DATA_WIDTH, 8, sample width; must match the blockram.
- PHASE_WIDTH, 32, accumulator width; must be greater than ADDR_WIDTH.
- CNT_WIDTH, 16, width of the period counter.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle start request.
- stop  in  1  one-cycle stop request.
- ftw_in  in  PHASE_WIDTH  frequency tuning word.
- ftw_load  in  1  strobe; captures ftw_in into the shadow register.
- phase_off  in  ADDR_WIDTH  address offset, added modulo 2^ADDR_WIDTH.
- cycles_in  in  CNT_WIDTH  number of table periods to play; 0 means continuous.
- mem_addr  out  ADDR_WIDTH  table address to the blockram.
- mem_data  in  DATA_WIDTH  blockram read data (combinational read).
- sample_out  out  DATA_WIDTH  registered sample.
- sample_valid  out  1  sample_out is a new sample this cycle.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a counted burst completes.

Behaviour:
- Clock and reset: one clock, synchronous active-high reset.
- Reset values: all outputs 0. Internally: phase=0, ftw_active=0, ftw_shadow=0, pending=0, cnt=0, state=IDLE.
- States: IDLE and RUN.
- IDLE -> RUN on start when stop is low. stop has priority if start and stop arrive together.
  - On this transition: phase<=0; cnt<=cycles_in.
  - ftw_active<=ftw_shadow; if ftw_load is high in the same cycle, ftw_active<=ftw_in instead. pending<=0.
- RUN, every cycle: {carry, phase} <= phase + ftw_active, wrapping modulo 2^PHASE_WIDTH. wrap = carry.
- Address: mem_addr = phase[PHASE_WIDTH-1 -: ADDR_WIDTH] + phase_off, modulo 2^ADDR_WIDTH.
  - Combinational from the registered phase; phase_off takes effect immediately.
- Sample path: in RUN, sample_out<=mem_data and sample_valid<=1. Latency from a mem_addr value to its sample is 1 clk.
  - Outside RUN, sample_valid<=0 and sample_out holds its last value.
- First sample: sample_valid first goes high 2 clks after the start pulse and carries table[phase_off].
- ftw_load in any state: ftw_shadow<=ftw_in; pending<=1.
  - In RUN, a pending word is applied on the next wrap cycle, so the new word is used from the next accumulation. This keeps the phase continuous.
  - A later ftw_load before the wrap overwrites the shadow; only the last word is applied.
- Period counting: on wrap with cnt!=0, cnt<=cnt-1. On wrap with cnt==1:
  - state->IDLE.
  - The sample for that cycle is still registered, with sample_valid high.
  - done=1 in the same cycle as that final sample_valid.
  - With cnt==0 (continuous), wrap never ends playback.
- stop in RUN: state->IDLE next edge, no done. The sample for the stop cycle's address is still emitted. phase and cnt hold.
- Ignored inputs: start while in RUN; stop while in IDLE.
- ftw_active==0 in RUN: phase frozen, the same sample repeats, no wrap, cnt frozen.
- Reset mid-RUN: the next edge gives the full reset state, and a pending ftw is discarded.
- busy = (state==RUN), registered.

Optional Feature:
- Macro: DDS_PHASE_DITHER_EN.
- Defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to the seed) advances each RUN cycle.
  - Its top min(16, PHASE_WIDTH-ADDR_WIDTH) bits are added to the truncated fraction bits before address extraction. Only the address is dithered; the accumulator itself is not.
  - This spreads truncation spurs.
- Undefined: no LFSR is present and the address is pure truncation, as described above.

Decomposition:
- Package dds_pkg holds:
  - typedef enum logic {IDLE, RUN} dds_state_t.
  - Default width localparams.
  - LFSR seed and tap constants.
- Sub-module dds_phase_acc: phase register, adder, carry/wrap output, ftw shadow/pending logic.
- The FSM, period counter, address offset and sample register stay in the top module.

Test Plan:
- Setup for all scenarios: defaults; blockram preloaded with table[i]=i[7:0]; ftw=2^20 (one address per clk); phase_off=0; cycles_in=0.
  - start -> sample_valid rises 2 clks later.
  - sample_out is 0,1,2,...,255,0 continuously; busy=1.
- cycles_in=2, ftw=2^20 -> exactly 8192 valid samples, then done is a single-cycle pulse on the last sample; busy=0 the next cycle.
- Playback running with ftw=2^20; ftw_load with ftw_in=2^21 mid-period -> the address step stays 1 until wrap, then becomes 2 (0,2,4,...). No discontinuity.
- phase_off=100, start -> first sample is table[100]=100. Changing to phase_off=0 mid-run shifts the samples on the next cycle.
- Corner controls:
  - stop and start in the same cycle from IDLE -> stays IDLE.
  - ftw_active=0 in RUN -> constant sample, done never asserts with cycles_in=1.
  - rst mid-run -> all outputs 0 next cycle.
- DDS_PHASE_DITHER_EN defined, ftw=2^19+1 -> the address sequence differs from the undithered run by at most +1.
  - The LFSR sequence after reset starts from 16'hACE1 and matches the reference model.
